// File: rtl/alu_seq_nbit_if.sv
// alu_seq_nbit_if: operand/result handshake bundle for alu_seq_nbit
//   master drives A, B, op_sel, in_valid, out_ready
//   slave drives in_ready, result, carry, zero, overflow, out_valid
interface alu_seq_nbit_if #(parameter int WIDTH = 8);
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic [2:0]       op_sel;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] result;
   logic             carry;
   logic             zero;
   logic             overflow;
   logic             out_valid;
   logic             out_ready;
   modport master (
      output A, B, op_sel, in_valid, out_ready,
      input  in_ready, result, carry, zero, overflow, out_valid
   );
   modport slave (
      input  A, B, op_sel, in_valid, out_ready,
      output in_ready, result, carry, zero, overflow, out_valid
   );
endinterface

// File: rtl/alu_seq_nbit.sv
// alu_seq_nbit: registered WIDTH-bit ALU with valid/ready handshake and shift-add multiply
//   clk   rising-edge clock
//   rst_n asynchronous active-low reset
//   bus   slave side of alu_seq_nbit_if (operands/op in, result/flags out)
module alu_seq_nbit #(
   parameter int WIDTH = 8
) (
   input logic          clk,
   input logic          rst_n,
   alu_seq_nbit_if.slave bus
);
   localparam int CW = $clog2(WIDTH);
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] MUL  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;
   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_AND = 3'b001;
   localparam logic [2:0] OP_SUB = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_SHL = 3'b101;
   localparam logic [2:0] OP_SHR = 3'b110;
   localparam logic [2:0] OP_MUL = 3'b111;
   logic [1:0]         state;
   logic [CW-1:0]      cnt;
   logic [2*WIDTH-1:0] mcand;
   logic [2*WIDTH-1:0] acc;
   logic [2*WIDTH-1:0] acc_nxt;
   logic [WIDTH-1:0]   mplier;
   logic [WIDTH:0]     sum;
   logic [WIDTH:0]     diff;
   logic [WIDTH-1:0]   alu_r;
   logic               alu_c;
   logic               alu_v;
   assign bus.in_ready  = state == IDLE;
   assign bus.out_valid = state == DONE;
   always_comb begin
      sum     = {1'b0, bus.A} + {1'b0, bus.B};
      diff    = {1'b0, bus.A} - {1'b0, bus.B};
      // shifting by >= WIDTH already yields zero in SV, so no explicit clamp
      alu_r   = bus.op_sel == OP_ADD ? sum[WIDTH-1:0] :
                bus.op_sel == OP_SUB ? diff[WIDTH-1:0] :
                bus.op_sel == OP_AND ? bus.A & bus.B :
                bus.op_sel == OP_OR  ? bus.A | bus.B :
                bus.op_sel == OP_XOR ? bus.A ^ bus.B :
                bus.op_sel == OP_SHL ? bus.A << bus.B :
                bus.op_sel == OP_SHR ? bus.A >> bus.B : '0;
      // diff[WIDTH] is the borrow out of the unsigned subtraction
      alu_c   = bus.op_sel == OP_ADD ? sum[WIDTH] :
                bus.op_sel == OP_SUB ? diff[WIDTH] : 1'b0;
      alu_v   = bus.op_sel == OP_ADD ? (bus.A[WIDTH-1] == bus.B[WIDTH-1]) && (sum[WIDTH-1] != bus.A[WIDTH-1]) :
                bus.op_sel == OP_SUB ? (bus.A[WIDTH-1] != bus.B[WIDTH-1]) && (diff[WIDTH-1] != bus.A[WIDTH-1]) : 1'b0;
      acc_nxt = acc + (mplier[0] ? mcand : '0);
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         cnt          <= '0;
         mcand        <= '0;
         mplier       <= '0;
         acc          <= '0;
         bus.result   <= '0;
         bus.carry    <= 1'b0;
         bus.zero     <= 1'b0;
         bus.overflow <= 1'b0;
      end else begin
         case (state)
            IDLE: if (bus.in_valid) begin
               if (bus.op_sel == OP_MUL) begin
                  state  <= MUL;
                  mcand  <= {{WIDTH{1'b0}}, bus.A};
                  mplier <= bus.B;
                  acc    <= '0;
                  cnt    <= '0;
               end else begin
                  state        <= DONE;
                  bus.result   <= alu_r;
                  bus.carry    <= alu_c;
                  bus.zero     <= alu_r == '0;
                  bus.overflow <= alu_v;
               end
            end
            MUL: begin
               acc    <= acc_nxt;
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               // the final iteration's sum is the full product; publish it directly
               if (cnt == CW'(WIDTH - 1)) begin
                  state        <= DONE;
                  cnt          <= '0;
                  bus.result   <= acc_nxt[WIDTH-1:0];
                  bus.carry    <= |acc_nxt[2*WIDTH-1:WIDTH];
                  bus.zero     <= acc_nxt[WIDTH-1:0] == '0;
                  bus.overflow <= 1'b0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DONE: if (bus.out_ready) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_alu_seq_nbit.sv
// tb_alu_seq_nbit: directed and random checks of alu_seq_nbit against an arithmetic reference model
module tb_alu_seq_nbit;
   localparam int W = 8;
   localparam longint M = 64'd1 << W;
   localparam logic [2:0] ADD = 3'b000, AND_ = 3'b001, SUB = 3'b010, OR_ = 3'b011;
   localparam logic [2:0] XOR_ = 3'b100, SHL = 3'b101, SHR = 3'b110, MUL = 3'b111;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   nvec = 0;
   int   nerr = 0;
   alu_seq_nbit_if #(.WIDTH(W)) bus ();
   alu_seq_nbit #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   always #5 clk = ~clk;
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   function automatic void model(input logic [2:0] op, input longint a, input longint b,
                                 output logic [W-1:0] r, output logic c, output logic z, output logic v);
      longint x;
      longint sa, sb, sx;
      x = 0; c = 1'b0; v = 1'b0;
      sa = (a >> (W - 1)) & 1;
      sb = (b >> (W - 1)) & 1;
      case (op)
         ADD:  begin x = a + b; c = x >= M; x = x % M; end
         SUB:  begin x = (a - b + M) % M; c = a < b; end
         AND_: x = a & b;
         OR_:  x = a | b;
         XOR_: x = a ^ b;
         SHL:  x = b >= W ? 0 : (a << b) % M;
         SHR:  x = b >= W ? 0 : a >> b;
         default: begin x = a * b; c = (x / M) != 0; x = x % M; end
      endcase
      sx = (x >> (W - 1)) & 1;
      if (op == ADD) v = (sa == sb) && (sx != sa);
      if (op == SUB) v = (sa != sb) && (sx != sa);
      r = W'(x);
      z = x == 0;
   endfunction
   task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      int n = 0;
      while (!bus.in_ready && n < 40) begin tick(); n++; end
      chk("in_ready_wait", 32'(bus.in_ready), 32'd1);
      bus.op_sel = op; bus.A = a; bus.B = b; bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      bus.A = W'($urandom); bus.B = W'($urandom); bus.op_sel = 3'($urandom);
   endtask
   task automatic expect_out(input string tag, input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W-1:0] r;
      logic c, z, v;
      int n = 1;
      while (!bus.out_valid && n < 40) begin
         chk({tag, "_busy_in_ready"}, 32'(bus.in_ready), 32'd0);
         tick(); n++;
      end
      model(op, longint'(a), longint'(b), r, c, z, v);
      chk({tag, "_latency"}, 32'(n), op == MUL ? 32'(W + 1) : 32'd1);
      chk({tag, "_result"}, 32'(bus.result), 32'(r));
      chk({tag, "_carry"}, 32'(bus.carry), 32'(c));
      chk({tag, "_zero"}, 32'(bus.zero), 32'(z));
      chk({tag, "_overflow"}, 32'(bus.overflow), 32'(v));
      chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd0);
   endtask
   task automatic consume(input string tag);
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      chk({tag, "_out_valid_drop"}, 32'(bus.out_valid), 32'd0);
      chk({tag, "_idle_in_ready"}, 32'(bus.in_ready), 32'd1);
   endtask
   task automatic run(input string tag, input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      issue(op, a, b);
      expect_out(tag, op, a, b);
      consume(tag);
   endtask
   initial begin
      logic [W-1:0] r;
      logic c, z, v;
      bus.A = '0; bus.B = '0; bus.op_sel = '0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
      repeat (2) tick();
      chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_result", 32'(bus.result), 32'd0);
      chk("rst_flags", {29'd0, bus.carry, bus.zero, bus.overflow}, 32'd0);
      rst_n = 1'b1;
      tick();
      run("add_carry", ADD, 8'hF0, 8'h20);
      run("and", AND_, 8'hF0, 8'h3C);
      run("add_ovf", ADD, 8'h7F, 8'h01);
      run("sub_zero", SUB, 8'h05, 8'h05);
      run("sub_borrow", SUB, 8'h03, 8'h05);
      run("sub_ovf", SUB, 8'h80, 8'h01);
      run("mul_c3", MUL, 8'h0F, 8'h0D);
      run("mul_hi", MUL, 8'h10, 8'h10);
      run("mul_max", MUL, 8'hFF, 8'hFF);
      run("shl1", SHL, 8'h81, 8'd1);
      run("shr7", SHR, 8'h81, 8'd7);
      run("shl8", SHL, 8'hFF, 8'd8);
      run("shr0", SHR, 8'hAA, 8'd0);
      run("shr200", SHR, 8'hFF, 8'd200);
      run("or", OR_, 8'h0F, 8'h30);
      run("xor", XOR_, 8'hFF, 8'h0F);
      // backpressure with a pending op held on the input
      issue(ADD, 8'h12, 8'h34);
      expect_out("bp", ADD, 8'h12, 8'h34);
      bus.op_sel = XOR_; bus.A = 8'h5A; bus.B = 8'hFF; bus.in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("bp_hold_valid", 32'(bus.out_valid), 32'd1);
         chk("bp_hold_result", 32'(bus.result), 32'h46);
         chk("bp_hold_in_ready", 32'(bus.in_ready), 32'd0);
      end
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      chk("bp_release_valid", 32'(bus.out_valid), 32'd0);
      chk("bp_release_in_ready", 32'(bus.in_ready), 32'd1);
      tick();
      bus.in_valid = 1'b0;
      expect_out("bp_pending", XOR_, 8'h5A, 8'hFF);
      consume("bp_pending");
      // reset in the middle of a multiply
      issue(MUL, 8'h0F, 8'h0D);
      repeat (3) tick();
      rst_n = 1'b0;
      #1;
      chk("mrst_in_ready", 32'(bus.in_ready), 32'd1);
      chk("mrst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("mrst_result", 32'(bus.result), 32'd0);
      chk("mrst_flags", {29'd0, bus.carry, bus.zero, bus.overflow}, 32'd0);
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < 12; i++) begin
         tick();
         chk("mrst_no_stale", 32'(bus.out_valid), 32'd0);
      end
      run("post_rst_add", ADD, 8'h01, 8'h01);
      // random operations with random backpressure
      for (int k = 0; k < 60; k++) begin
         logic [2:0] op;
         logic [W-1:0] a, b;
         int hold;
         op = 3'($urandom);
         a = W'($urandom);
         b = (op == SHL || op == SHR) ? W'($urandom_range(0, 10)) : W'($urandom);
         hold = $urandom_range(0, 2);
         issue(op, a, b);
         expect_out("rnd", op, a, b);
         model(op, longint'(a), longint'(b), r, c, z, v);
         for (int i = 0; i < hold; i++) begin
            tick();
            chk("rnd_hold", {bus.result, bus.carry, bus.zero, bus.overflow, bus.out_valid}, {r, c, z, v, 1'b1});
         end
         consume("rnd");
      end
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule

// File: doc/alu_seq_nbit.md
Name: alu_seq_nbit

Overview:
- Parametrised, registered successor of the team's 4-bit combinational ALU.
- WIDTH-bit operands and a 3-bit opcode. Opcodes 000/001 keep their previous ADD/AND meaning; SUB, OR, XOR, shifts and a multi-cycle shift-add multiply are added.
- Operands enter through a valid/ready handshake. Result plus carry/zero/overflow flags are held on a valid/ready output until consumed.
- Sits between the operand register file and the writeback stage of the datapath.

Parameters:
WIDTH  8  operand/result width in bits (>= 2)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
A  input  WIDTH  operand A
B  input  WIDTH  operand B (shift amount for SHL/SHR)
op_sel  input  3  operation code
in_valid  input  1  operands/op_sel valid
in_ready  output  1  block can accept a new operation
result  output  WIDTH  registered result
carry  output  1  carry/borrow/multiply-high flag
zero  output  1  result == 0
overflow  output  1  signed overflow (ADD/SUB only)
out_valid  output  1  result and flags valid
out_ready  input  1  consumer takes result

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: state IDLE, in_ready=1, out_valid=0, result=0, carry=0, zero=0, overflow=0, multiply counter=0.
  - Reset asserted mid-operation (any state) aborts the operation immediately. No output from it ever appears.
- Opcodes: 000 ADD, 001 AND, 010 SUB, 011 OR, 100 XOR, 101 SHL, 110 SHR (logical), 111 MUL.
- Handshake:
  - Accept when in_valid && in_ready at a rising edge.
  - in_ready = (state==IDLE) only; there is no overlap of operations.
  - A, B and op_sel are captured on accept and may change afterwards.
  - out_valid stays high, with result and flags stable, until the edge where out_ready=1; that edge returns the block to IDLE.
  - out_ready while out_valid=0 is ignored.
- FSM:
  - IDLE -> DONE on accept of any non-MUL op.
  - IDLE -> MUL on accept of MUL.
  - MUL -> DONE after WIDTH iterations.
  - DONE -> IDLE on out_ready.
- Latency:
  - Non-MUL: result registered at the accept edge; out_valid high in the following cycle (1 cycle).
  - MUL: one shift-add iteration per cycle for WIDTH cycles; out_valid high WIDTH+1 cycles after accept (WIDTH=8: 9 cycles).
- Arithmetic and flags:
  - ADD: result = (A+B) mod 2^WIDTH; carry = bit WIDTH of the sum; overflow = A and B same sign and result sign differs.
  - SUB: result = (A-B) mod 2^WIDTH; carry = borrow (1 iff A<B unsigned); overflow = A and B signs differ and result sign differs from A.
  - AND/OR/XOR: bitwise; carry=0, overflow=0.
  - SHL/SHR: shift A by unsigned B. B >= WIDTH gives result 0. B=0 gives result A. carry=0, overflow=0.
  - MUL: unsigned; result = low WIDTH bits of A*B; carry = 1 iff the high WIDTH bits are nonzero; overflow=0.
  - zero = (result==0) for every op, including MUL.
- Boundaries:
  - in_valid held high during MUL or DONE is not accepted and the operation is not lost; it is accepted in the first IDLE cycle.
  - out_ready and in_valid both high in DONE: the DONE->IDLE transition is taken; the new op is accepted next cycle.
  - MUL counter runs 0..WIDTH-1 and does not wrap into a second pass.

Test Plan:
1. WIDTH=8, reset released, op=ADD A=0xF0 B=0x20 -> after 1 cycle out_valid=1, result=0x10, carry=1, zero=0, overflow=0. op=AND A=0xF0 B=0x3C -> result=0x30.
2. op=ADD A=0x7F B=0x01 -> result=0x80, overflow=1, carry=0. op=SUB A=0x05 B=0x05 -> result=0x00, zero=1, carry=0. op=SUB A=0x03 B=0x05 -> result=0xFE, carry=1.
3. op=MUL A=0x0F B=0x0D -> in_ready=0 for 9 cycles, out_valid at cycle 9, result=0xC3, carry=0. op=MUL A=0x10 B=0x10 -> result=0x00, carry=1, zero=1.
4. op=SHL A=0x81 B=1 -> 0x02. op=SHR A=0x81 B=7 -> 0x01. op=SHL A=0xFF B=8 -> 0x00, zero=1. op=SHR A=0xAA B=0 -> 0xAA.
5. Backpressure: out_ready=0 for 5 cycles after out_valid -> result and flags stable, in_ready=0, a pending in_valid is not accepted. out_ready=1 -> IDLE, then the pending op is accepted and its result appears.
6. Pulse rst_n low at MUL cycle 4 -> all outputs 0 and in_ready=1 immediately. After release, a fresh ADD 0x01+0x01 -> result=0x02 with no stale MUL output.
